td4_prog_ctrl: RTL and testbench

Program-memory owner and run controller for the 4-bit TD4 CPU core. Holds the 16x8 instruction ROM image and shares it between a byte-stream loader and CPU instruction fetch. Sequences the CPU through reset, free-run at a divided rate, single-step and halt, using a clock-enable and a CPU reset output. Sits between the board-level switch/UART front end and the cpu core.

---
 rtl/td4_pkg.sv | 23 ++
 rtl/td4_prog_ctrl_if.sv | 31 +++
 rtl/td4_prog_mem.sv | 37 +++
 rtl/td4_prog_ctrl.sv | 108 ++++++++++
 tb/tb_td4_prog_ctrl.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/td4_pkg.sv
// Shared types and constants for the TD4 program-memory controller.
package td4_pkg;

  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);
  localparam int DW    = 8;

  // Instruction word layout: opcode in the upper nibble, immediate below.
  localparam int OP_MSB = 7;
  localparam int OP_LSB = 4;
  localparam int IM_MSB = 3;
  localparam int IM_LSB = 0;

  localparam logic [DW-1:0] NOP_WORD = 8'h00;

  typedef enum logic [1:0] {
    S_CPURST = 2'd0,
    S_HALT   = 2'd1,
    S_LOAD   = 2'd2,
    S_RUN    = 2'd3
  } state_e;

endpackage

// File: rtl/td4_prog_ctrl_if.sv
// Command, loader and fetch signals between the front end / CPU and the controller.
interface td4_prog_ctrl_if;
  import td4_pkg::*;

  logic          cmd_run;
  logic          cmd_step;
  logic          cmd_halt;
  logic          cmd_load;
  logic          ld_valid;
  logic [DW-1:0] ld_data;
  logic          ld_ready;
  logic          ld_done;
  logic [AW-1:0] fetch_addr;
  logic [DW-1:0] fetch_data;
  logic          cpu_en;
  logic          cpu_n_rst;
  logic [1:0]    run_state;

  // Front end / CPU side.
  modport master (
    output cmd_run, cmd_step, cmd_halt, cmd_load, ld_valid, ld_data, fetch_addr,
    input  ld_ready, ld_done, fetch_data, cpu_en, cpu_n_rst, run_state
  );

  // Controller side.
  modport slave (
    input  cmd_run, cmd_step, cmd_halt, cmd_load, ld_valid, ld_data, fetch_addr,
    output ld_ready, ld_done, fetch_data, cpu_en, cpu_n_rst, run_state
  );

endinterface

// File: rtl/td4_prog_mem.sv
// Program store: DEPTH x DW registers, synchronous write and clear, combinational read.
module td4_prog_mem
  import td4_pkg::*;
(
  input  logic          clk,
  input  logic          clr,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];

  // Next image: clear wins over a write so a reset always yields an all-NOP program.
  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_d[i] = NOP_WORD;
      end
    end
  end

  // Word storage.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/td4_prog_ctrl.sv
// Run controller: owns the program image, sequences CPU reset/run/step/halt and loading.
module td4_prog_ctrl
  import td4_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  td4_prog_ctrl_if.slave   bus
);

  // Divider needs at least one bit even when DIV==1 (count then stays at 0).
  localparam int            CW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          step_q, step_d;
  logic          done_q, done_d;
  logic          wr_en;
  logic [DW-1:0] mem_rdata;

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= S_CPURST;
      cnt_q   <= '0;
      ptr_q   <= '0;
      step_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      step_q  <= step_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic; commands are resolved halt > load > step > run.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    step_d  = 1'b0;
    done_d  = 1'b0;
    wr_en   = 1'b0;
    case (state_q)
      S_CPURST: state_d = S_HALT;
      S_HALT: begin
        if (!bus.cmd_halt) begin
          if (bus.cmd_load) begin
            state_d = S_LOAD;
            ptr_d   = '0;
          end else if (bus.cmd_step) begin
            step_d = 1'b1;
          end else if (bus.cmd_run) begin
            state_d = S_RUN;
            cnt_d   = '0;
          end
        end
      end
      S_LOAD: begin
        // A byte offered alongside an abort is still written.
        if (bus.ld_valid) begin
          wr_en = 1'b1;
          ptr_d = ptr_q + AW'(1);
        end
        if (bus.cmd_halt) begin
          state_d = S_CPURST;
        end else if (bus.ld_valid && ptr_q == AW'(DEPTH - 1)) begin
          state_d = S_CPURST;
          done_d  = 1'b1;
        end
      end
      S_RUN: begin
        cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
        if (bus.cmd_halt) begin
          state_d = S_HALT;
        end else if (bus.cmd_load) begin
          state_d = S_LOAD;
          ptr_d   = '0;
        end
      end
      default: state_d = S_CPURST;
    endcase
  end

  td4_prog_mem u_mem (
    .clk   (clk),
    .clr   (!n_rst),
    .we    (wr_en),
    .waddr (ptr_q),
    .wdata (bus.ld_data),
    .raddr (bus.fetch_addr),
    .rdata (mem_rdata)
  );

  // CPU is held in reset while loading, so it never fetches a partial image.
  assign bus.cpu_n_rst  = !(state_q == S_CPURST || state_q == S_LOAD);
  assign bus.ld_ready   = (state_q == S_LOAD);
  assign bus.ld_done    = done_q;
  assign bus.cpu_en     = (state_q == S_RUN && cnt_q == CNT_LAST) || step_q;
  assign bus.run_state  = state_q;
  assign bus.fetch_data = bus.cpu_n_rst ? mem_rdata : NOP_WORD;

endmodule

// File: tb/tb_td4_prog_ctrl.sv
// Self-checking bench for td4_prog_ctrl: directed scenarios plus random traffic vs. a model.
module tb_td4_prog_ctrl;
  import td4_pkg::*;

  localparam int DIV = 4;

  logic clk = 1'b0;
  logic n_rst;

  td4_prog_ctrl_if bus ();

  td4_prog_ctrl #(.DIV(DIV)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  always #50 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // State as plain int, run progress as "cycles since entering RUN" (1-based).
  int       m_state;
  int       m_ptr;
  int       m_age;
  bit       m_step;
  bit       m_done;
  bit       m_valid = 1'b0;
  bit [7:0] m_mem [16];

  always @(negedge clk) begin : scoreboard
    int exp_nrst;
    int exp_en;
    int exp_fd;
    int nxt;
    bit last;
    bit nstep;
    bit ndone;
    if (m_valid) begin
      exp_nrst = (m_state == 0 || m_state == 2) ? 0 : 1;
      exp_en   = ((m_state == 3 && (m_age % DIV) == 0) || m_step) ? 1 : 0;
      exp_fd   = exp_nrst ? int'(m_mem[bus.fetch_addr]) : 0;
      check("run_state",  int'(bus.run_state),  m_state);
      check("cpu_n_rst",  int'(bus.cpu_n_rst),  exp_nrst);
      check("ld_ready",   int'(bus.ld_ready),   (m_state == 2) ? 1 : 0);
      check("ld_done",    int'(bus.ld_done),    int'(m_done));
      check("cpu_en",     int'(bus.cpu_en),     exp_en);
      check("fetch_data", int'(bus.fetch_data), exp_fd);
    end
    if (!n_rst) begin
      m_state = 0;
      for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
      m_ptr   = 0;
      m_age   = 0;
      m_step  = 1'b0;
      m_done  = 1'b0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      nxt   = m_state;
      nstep = 1'b0;
      ndone = 1'b0;
      last  = 1'b0;
      case (m_state)
        0: nxt = 1;
        1: if (!bus.cmd_halt) begin
             if (bus.cmd_load) begin nxt = 2; m_ptr = 0; end
             else if (bus.cmd_step) nstep = 1'b1;
             else if (bus.cmd_run) nxt = 3;
           end
        2: begin
             if (bus.ld_valid) begin
               m_mem[m_ptr] = bus.ld_data;
               last  = (m_ptr == 15);
               m_ptr = (m_ptr + 1) % 16;
             end
             if (bus.cmd_halt) nxt = 0;
             else if (last) begin nxt = 0; ndone = 1'b1; end
           end
        default: begin
             if (bus.cmd_halt) nxt = 1;
             else if (bus.cmd_load) begin nxt = 2; m_ptr = 0; end
           end
      endcase
      m_age   = (nxt == 3) ? ((m_state == 3) ? m_age + 1 : 1) : 0;
      m_state = nxt;
      m_step  = nstep;
      m_done  = ndone;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input bit rst_n, input bit run, input bit step, input bit halt,
                       input bit load, input bit v, input logic [7:0] d, input logic [3:0] fa);
    @(posedge clk);
    #1;
    n_rst         = rst_n;
    bus.cmd_run   = run;
    bus.cmd_step  = step;
    bus.cmd_halt  = halt;
    bus.cmd_load  = load;
    bus.ld_valid  = v;
    bus.ld_data   = d;
    bus.fetch_addr = fa;
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0);
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  int pulses;

  initial begin
    n_rst          = 1'b0;
    bus.cmd_run    = 1'b0;
    bus.cmd_step   = 1'b0;
    bus.cmd_halt   = 1'b0;
    bus.cmd_load   = 1'b0;
    bus.ld_valid   = 1'b0;
    bus.ld_data    = 8'h00;
    bus.fetch_addr = 4'd0;

    // Reset sequence.
    repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0);
    idle(); sample();
    check("rst_c0_state", int'(bus.run_state), 0);
    check("rst_c0_nrst",  int'(bus.cpu_n_rst), 0);
    check("rst_c0_en",    int'(bus.cpu_en),    0);
    idle(); sample();
    check("rst_c1_state", int'(bus.run_state), 1);
    check("rst_c1_nrst",  int'(bus.cpu_n_rst), 1);
    check("rst_c1_en",    int'(bus.cpu_en),    0);

    // Full load with a 2-cycle valid gap.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 4'd0);
    for (int i = 0; i < 16; i++) begin
      if (i == 8) begin
        repeat (2) begin
          drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hEE, 4'(i));
          sample();
          check("load_gap_fetch0", int'(bus.fetch_data), 0);
        end
      end
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'(8'hB1 + i), 4'(i));
      sample();
      check("load_fetch0", int'(bus.fetch_data), 0);
      check("load_ready",  int'(bus.ld_ready),   1);
    end
    idle(); sample();
    check("load_done",       int'(bus.ld_done),   1);
    check("load_done_state", int'(bus.run_state), 0);
    idle(); sample();
    check("load_done_once",  int'(bus.ld_done),   0);
    bus.fetch_addr = 4'd0;
    #1 check("fetch_w0",  int'(bus.fetch_data), 'hB1);
    bus.fetch_addr = 4'd15;
    #1 check("fetch_w15", int'(bus.fetch_data), 'hC0);

    // Run at divided rate; halt lands on the 20th (pulse) cycle.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0);
    pulses = 0;
    for (int i = 1; i <= 20; i++) begin
      if (i == 20) drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0);
      else idle();
      sample();
      check("run_en", int'(bus.cpu_en), (i % 4 == 0) ? 1 : 0);
      pulses += int'(bus.cpu_en);
    end
    check("run_pulses", pulses, 5);
    for (int i = 0; i < 5; i++) begin
      idle(); sample();
      check("halted_state", int'(bus.run_state), 1);
      check("halted_en",    int'(bus.cpu_en),    0);
    end

    // Two single steps 3 cycles apart.
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, (i == 0 || i == 3), 1'b0, 1'b0, 1'b0, 8'h00, 4'd0);
      sample();
      check("step_en",    int'(bus.cpu_en),    (i == 1 || i == 4) ? 1 : 0);
      check("step_state", int'(bus.run_state), 1);
      pulses += int'(bus.cpu_en);
    end
    check("step_pulses", pulses, 2);

    // Halt beats run in the same cycle.
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0);
    repeat (3) begin
      idle(); sample();
      check("prio_state", int'(bus.run_state), 1);
      check("prio_en",    int'(bus.cpu_en),    0);
    end

    // Abort a load after 5 bytes.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 4'd0);
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'(8'h10 + i), 4'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 4'd0);
    sample();
    check("abort_state", int'(bus.run_state), 2);
    idle(); sample();
    check("abort_cpurst", int'(bus.run_state), 0);
    check("abort_nodone", int'(bus.ld_done),   0);
    idle(); sample();
    for (int a = 0; a < 16; a++) begin
      bus.fetch_addr = 4'(a);
      #1 check("abort_word", int'(bus.fetch_data), (a < 5) ? ('h10 + a) : ('hB1 + a));
    end

    // Random traffic against the model.
    repeat (4000) begin
      drive(($urandom % 500) != 0, ($urandom % 10) == 0, ($urandom % 8) == 0,
            ($urandom % 40) == 0, ($urandom % 20) == 0, ($urandom % 2) == 0,
            8'($urandom), 4'($urandom));
    end
    idle();
    sample();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
